mc_control_fsm: RTL and testbench



---
 rtl/mc_control_fsm_if.sv | 43 ++++
 rtl/mc_control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: bundles the sequencer's decode inputs and datapath control outputs.
//   master: the sequencer (drives control, samples opcode/func/bcond/mem_ack)
//   slave : the datapath/memory side (drives opcode/func/bcond/mem_ack, samples control)
interface mc_control_fsm_if;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        bcond;
  logic        mem_ack;

  logic        ir_write;
  logic        mdr_write;
  logic        mem_read;
  logic        mem_write;
  logic        i_or_d;
  logic        alu_src_A;
  logic [1:0]  alu_src_B;
  logic [1:0]  alu_op;
  logic        reg_store;
  logic        branch_dst_store;
  logic        reg_write;
  logic        reg_dst;
  logic        pc_to_reg;
  logic [1:0]  wb_src;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        output_write;
  logic [15:0] num_inst;
  logic        is_halted;

  modport master (
    input  opcode, func, bcond, mem_ack,
    output ir_write, mdr_write, mem_read, mem_write, i_or_d, alu_src_A, alu_src_B, alu_op,
           reg_store, branch_dst_store, reg_write, reg_dst, pc_to_reg, wb_src, pc_write,
           pc_src, output_write, num_inst, is_halted
  );

  modport slave (
    output opcode, func, bcond, mem_ack,
    input  ir_write, mdr_write, mem_read, mem_write, i_or_d, alu_src_A, alu_src_B, alu_op,
           reg_store, branch_dst_store, reg_write, reg_dst, pc_to_reg, wb_src, pc_write,
           pc_src, output_write, num_inst, is_halted
  );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle IF/ID/EX/MEM/WB sequencer for the 16-bit TSC CPU datapath.
// Control outputs are combinational from state, opcode/func, bcond and mem_ack, and are
// forced to zero while reset_n is low.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   ctrl    - mc_control_fsm_if.master: decode inputs in, datapath/memory control out,
//             completed-instruction count (num_inst) and halt flag out
// Configuration macro: INST_COUNT_EN enables the 16-bit num_inst counter; otherwise
// num_inst is tied to zero and no counter flops exist.
module mc_control_fsm (
  input logic              clk,
  input logic              reset_n,
  mc_control_fsm_if.master ctrl
);

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} state_e;

  localparam logic [3:0] OpBlz   = 4'd3;
  localparam logic [3:0] OpAdi   = 4'd4;
  localparam logic [3:0] OpLhi   = 4'd6;
  localparam logic [3:0] OpLwd   = 4'd7;
  localparam logic [3:0] OpSwd   = 4'd8;
  localparam logic [3:0] OpJmp   = 4'd9;
  localparam logic [3:0] OpJal   = 4'd10;
  localparam logic [3:0] OpRtype = 4'd15;

  localparam logic [5:0] FnAluMax = 6'd7;
  localparam logic [5:0] FnJpr    = 6'd25;
  localparam logic [5:0] FnJrl    = 6'd26;
  localparam logic [5:0] FnWwd    = 6'd28;
  localparam logic [5:0] FnHlt    = 6'd29;

  state_e state_q, state_d;

  // Instruction class decode; IR is stable from ID onward.
  logic is_rtype, is_alu_r, is_jpr, is_jrl, is_wwd, is_hlt;
  logic is_branch, is_imm, is_mem, is_lwd;

  always_comb begin
    is_rtype  = (ctrl.opcode == OpRtype);
    is_alu_r  = is_rtype && (ctrl.func <= FnAluMax);
    is_jpr    = is_rtype && (ctrl.func == FnJpr);
    is_jrl    = is_rtype && (ctrl.func == FnJrl);
    is_wwd    = is_rtype && (ctrl.func == FnWwd);
    is_hlt    = is_rtype && (ctrl.func == FnHlt);
    is_branch = (ctrl.opcode <= OpBlz);
    is_imm    = (ctrl.opcode >= OpAdi) && (ctrl.opcode <= OpLhi);
    is_lwd    = (ctrl.opcode == OpLwd);
    is_mem    = is_lwd || (ctrl.opcode == OpSwd);
  end

  // Ungated control values; gated by reset_n on the way out.
  logic       ir_write, mdr_write, mem_read, mem_write, i_or_d, alu_src_A;
  logic [1:0] alu_src_B, alu_op, wb_src, pc_src;
  logic       reg_store, branch_dst_store, reg_write, reg_dst, pc_to_reg;
  logic       pc_write, output_write;

  always_comb begin
    state_d          = state_q;
    ir_write         = 1'b0;
    mdr_write        = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    i_or_d           = 1'b0;
    alu_src_A        = 1'b0;
    alu_src_B        = 2'd0;
    alu_op           = 2'b00;
    reg_store        = 1'b0;
    branch_dst_store = 1'b0;
    reg_write        = 1'b0;
    reg_dst          = 1'b0;
    pc_to_reg        = 1'b0;
    wb_src           = 2'd0;
    pc_write         = 1'b0;
    pc_src           = 2'd0;
    output_write     = 1'b0;

    unique case (state_q)
      StIf: begin
        mem_read  = 1'b1;
        alu_src_B = 2'd2;
        reg_store = 1'b1;
        ir_write  = ctrl.mem_ack;
        if (ctrl.mem_ack) state_d = StId;
      end

      StId: begin
        alu_src_B        = 2'd1;
        alu_op           = 2'b11;
        branch_dst_store = 1'b1;
        if (is_hlt) begin
          state_d = StHalt;
        end else if (ctrl.opcode == OpJmp || ctrl.opcode == OpJal) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          state_d  = StIf;
          if (ctrl.opcode == OpJal) begin
            reg_write = 1'b1;
            pc_to_reg = 1'b1;
            wb_src    = 2'd2;
          end
        end else if (is_jpr || is_jrl) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
          state_d  = StIf;
          if (is_jrl) begin
            reg_write = 1'b1;
            pc_to_reg = 1'b1;
            wb_src    = 2'd2;
          end
        end else if (is_alu_r || is_branch || is_imm || is_mem) begin
          state_d = StEx;
        end else begin
          // WWD and any unknown opcode/func retire here, advancing to next_pc.
          output_write = is_wwd;
          pc_write     = 1'b1;
          pc_src       = 2'd0;
          state_d      = StIf;
        end
      end

      StEx: begin
        alu_src_A = 1'b1;
        state_d   = StIf;
        if (is_alu_r) begin
          alu_op  = 2'b10;
          state_d = StWb;
        end else if (is_imm) begin
          alu_src_B = 2'd1;
          alu_op    = 2'b10;
          state_d   = StWb;
        end else if (is_mem) begin
          alu_src_B = 2'd1;
          state_d   = StMem;
        end else if (is_branch) begin
          alu_op   = 2'b01;
          pc_write = 1'b1;
          pc_src   = {1'b0, ctrl.bcond};
        end
      end

      StMem: begin
        // Address operands held so ALU out stays valid across wait states.
        alu_src_A = 1'b1;
        alu_src_B = 2'd1;
        i_or_d    = 1'b1;
        if (is_lwd) begin
          mem_read  = 1'b1;
          mdr_write = ctrl.mem_ack;
          if (ctrl.mem_ack) state_d = StWb;
        end else begin
          mem_write = 1'b1;
          if (ctrl.mem_ack) begin
            pc_write = 1'b1;
            state_d  = StIf;
          end
        end
      end

      StWb: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        wb_src    = is_lwd ? 2'd1 : 2'd0;
        reg_dst   = is_rtype;
        state_d   = StIf;
      end

      StHalt: state_d = StHalt;

      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIf;
    else          state_q <= state_d;
  end

  assign ctrl.ir_write         = reset_n & ir_write;
  assign ctrl.mdr_write        = reset_n & mdr_write;
  assign ctrl.mem_read         = reset_n & mem_read;
  assign ctrl.mem_write        = reset_n & mem_write;
  assign ctrl.i_or_d           = reset_n & i_or_d;
  assign ctrl.alu_src_A        = reset_n & alu_src_A;
  assign ctrl.alu_src_B        = reset_n ? alu_src_B : 2'd0;
  assign ctrl.alu_op           = reset_n ? alu_op : 2'd0;
  assign ctrl.reg_store        = reset_n & reg_store;
  assign ctrl.branch_dst_store = reset_n & branch_dst_store;
  assign ctrl.reg_write        = reset_n & reg_write;
  assign ctrl.reg_dst          = reset_n & reg_dst;
  assign ctrl.pc_to_reg        = reset_n & pc_to_reg;
  assign ctrl.wb_src           = reset_n ? wb_src : 2'd0;
  assign ctrl.pc_write         = reset_n & pc_write;
  assign ctrl.pc_src           = reset_n ? pc_src : 2'd0;
  assign ctrl.output_write     = reset_n & output_write;
  assign ctrl.is_halted        = reset_n & (state_q == StHalt);

`ifdef INST_COUNT_EN
  logic [15:0] num_inst_q;
  logic        inst_done;

  // HLT retires on its ID->HALT edge even though it never strobes pc_write.
  assign inst_done = pc_write || (state_q == StId && is_hlt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       num_inst_q <= 16'h0000;
    else if (inst_done) num_inst_q <= num_inst_q + 16'd1;
  end

  assign ctrl.num_inst = num_inst_q;
`else
  assign ctrl.num_inst = 16'h0000;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  typedef struct packed {
    logic       ir_write;
    logic       mdr_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       alu_src_A;
    logic [1:0] alu_src_B;
    logic [1:0] alu_op;
    logic       reg_store;
    logic       branch_dst_store;
    logic       reg_write;
    logic       reg_dst;
    logic       pc_to_reg;
    logic [1:0] wb_src;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       output_write;
    logic       is_halted;
  } ctl_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  logic [15:0] exp_cnt;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c.ir_write         = bus.ir_write;
    c.mdr_write        = bus.mdr_write;
    c.mem_read         = bus.mem_read;
    c.mem_write        = bus.mem_write;
    c.i_or_d           = bus.i_or_d;
    c.alu_src_A        = bus.alu_src_A;
    c.alu_src_B        = bus.alu_src_B;
    c.alu_op           = bus.alu_op;
    c.reg_store        = bus.reg_store;
    c.branch_dst_store = bus.branch_dst_store;
    c.reg_write        = bus.reg_write;
    c.reg_dst          = bus.reg_dst;
    c.pc_to_reg        = bus.pc_to_reg;
    c.wb_src           = bus.wb_src;
    c.pc_write         = bus.pc_write;
    c.pc_src           = bus.pc_src;
    c.output_write     = bus.output_write;
    c.is_halted        = bus.is_halted;
    return c;
  endfunction

  // Hand-written expected control words per state.
  function automatic ctl_t c_if(input logic ack);
    ctl_t c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_B = 2'd2;
    c.reg_store = 1'b1;
    c.ir_write  = ack;
    return c;
  endfunction

  function automatic ctl_t c_id();
    ctl_t c = '0;
    c.alu_src_B        = 2'd1;
    c.alu_op           = 2'b11;
    c.branch_dst_store = 1'b1;
    return c;
  endfunction

  function automatic logic [15:0] exp_num(input logic [15:0] cnt);
`ifdef INST_COUNT_EN
    return cnt;
`else
    return (cnt & 16'h0000);
`endif
  endfunction

  // Called at posedge+1: settle, compare, advance to next posedge+1.
  task automatic step_chk(input string tag, input ctl_t exp);
    #1;
    check_eq(tag, 32'(observed()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_num(input string tag);
    check_eq(tag, 32'(bus.num_inst), 32'(exp_num(exp_cnt)));
  endtask

  ctl_t e;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    exp_cnt     = 16'h0;
    reset_n     = 1'b0;
    bus.opcode  = 4'hF;
    bus.func    = 6'd0;
    bus.bcond   = 1'b0;
    bus.mem_ack = 1'b1;

    // Reset: all control low, counter zero.
    repeat (2) @(posedge clk);
    #2;
    check_eq("reset_ctl", 32'(observed()), 32'h0);
    chk_num("reset_num");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // ADD (0xF000): IF ID EX WB.
    step_chk("add_if", c_if(1'b1));
    step_chk("add_id", c_id());
    e = '0; e.alu_src_A = 1; e.alu_op = 2'b10;
    step_chk("add_ex", e);
    e = '0; e.reg_write = 1; e.pc_write = 1; e.reg_dst = 1;
    step_chk("add_wb", e);
    exp_cnt++;
    chk_num("add_num");

    // LWD (0x7000), MEM waits two cycles.
    bus.opcode = 4'd7;
    step_chk("lwd_if", c_if(1'b1));
    step_chk("lwd_id", c_id());
    e = '0; e.alu_src_A = 1; e.alu_src_B = 2'd1;
    step_chk("lwd_ex", e);
    bus.mem_ack = 1'b0;
    e = '0; e.alu_src_A = 1; e.alu_src_B = 2'd1; e.i_or_d = 1; e.mem_read = 1;
    step_chk("lwd_mem_w1", e);
    step_chk("lwd_mem_w2", e);
    bus.mem_ack = 1'b1;
    e.mdr_write = 1;
    step_chk("lwd_mem_ack", e);
    e = '0; e.reg_write = 1; e.pc_write = 1; e.wb_src = 2'd1;
    step_chk("lwd_wb", e);
    exp_cnt++;
    chk_num("lwd_num");

    // BEQ (0x1000) taken.
    bus.opcode = 4'd1;
    bus.bcond  = 1'b1;
    step_chk("beq_t_if", c_if(1'b1));
    step_chk("beq_t_id", c_id());
    e = '0; e.alu_src_A = 1; e.alu_op = 2'b01; e.pc_write = 1; e.pc_src = 2'd1;
    step_chk("beq_t_ex", e);
    exp_cnt++;

    // BEQ not taken, with one fetch wait cycle.
    bus.bcond   = 1'b0;
    bus.mem_ack = 1'b0;
    step_chk("beq_n_if_wait", c_if(1'b0));
    bus.mem_ack = 1'b1;
    step_chk("beq_n_if", c_if(1'b1));
    step_chk("beq_n_id", c_id());
    e.pc_src = 2'd0;
    step_chk("beq_n_ex", e);
    exp_cnt++;
    chk_num("beq_num");

    // JAL (0xA000).
    bus.opcode = 4'd10;
    step_chk("jal_if", c_if(1'b1));
    e = c_id(); e.pc_write = 1; e.pc_src = 2'd2; e.reg_write = 1; e.pc_to_reg = 1;
    e.wb_src = 2'd2;
    step_chk("jal_id", e);
    exp_cnt++;

    // JRL (0xF01A).
    bus.opcode = 4'd15;
    bus.func   = 6'd26;
    step_chk("jrl_if", c_if(1'b1));
    e = c_id(); e.pc_write = 1; e.pc_src = 2'd3; e.reg_write = 1; e.pc_to_reg = 1;
    e.wb_src = 2'd2;
    step_chk("jrl_id", e);
    exp_cnt++;

    // WWD (0xF01C).
    bus.func = 6'd28;
    step_chk("wwd_if", c_if(1'b1));
    e = c_id(); e.output_write = 1; e.pc_write = 1;
    step_chk("wwd_id", e);
    exp_cnt++;

    // Unknown opcode 12 retires as NOP in ID.
    bus.opcode = 4'd12;
    step_chk("nop_if", c_if(1'b1));
    e = c_id(); e.pc_write = 1;
    step_chk("nop_id", e);
    exp_cnt++;

    // ORI (0x5000): I-type writeback uses reg_dst=0.
    bus.opcode = 4'd5;
    step_chk("ori_if", c_if(1'b1));
    step_chk("ori_id", c_id());
    e = '0; e.alu_src_A = 1; e.alu_src_B = 2'd1; e.alu_op = 2'b10;
    step_chk("ori_ex", e);
    e = '0; e.reg_write = 1; e.pc_write = 1;
    step_chk("ori_wb", e);
    exp_cnt++;

    // SWD (0x8000) zero-wait.
    bus.opcode = 4'd8;
    step_chk("swd_if", c_if(1'b1));
    step_chk("swd_id", c_id());
    e = '0; e.alu_src_A = 1; e.alu_src_B = 2'd1;
    step_chk("swd_ex", e);
    e = '0; e.alu_src_A = 1; e.alu_src_B = 2'd1; e.i_or_d = 1; e.mem_write = 1;
    e.pc_write = 1;
    step_chk("swd_mem", e);
    exp_cnt++;
    chk_num("swd_num");

    // SWD aborted by reset while waiting in MEM.
    step_chk("swd2_if", c_if(1'b1));
    step_chk("swd2_id", c_id());
    e = '0; e.alu_src_A = 1; e.alu_src_B = 2'd1;
    step_chk("swd2_ex", e);
    bus.mem_ack = 1'b0;
    #1;
    e = '0; e.alu_src_A = 1; e.alu_src_B = 2'd1; e.i_or_d = 1; e.mem_write = 1;
    check_eq("swd2_mem_wait", 32'(observed()), 32'(e));
    reset_n = 1'b0;
    #1;
    check_eq("abort_mem_write", 32'(bus.mem_write), 32'h0);
    check_eq("abort_ctl", 32'(observed()), 32'h0);
    exp_cnt = 16'h0;
    chk_num("abort_num");
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b1;
    reset_n     = 1'b1;

    // HLT (0xF01D) after restart.
    bus.opcode = 4'd15;
    bus.func   = 6'd29;
    step_chk("hlt_if", c_if(1'b1));
    step_chk("hlt_id", c_id());
    exp_cnt++;
    e = '0; e.is_halted = 1;
    for (int i = 0; i < 10; i++) step_chk($sformatf("halt_%0d", i), e);
    chk_num("halt_num");

    // Reset out of HALT.
    reset_n = 1'b0;
    #1;
    exp_cnt = 16'h0;
    check_eq("halt_rst_ctl", 32'(observed()), 32'h0);
    chk_num("halt_rst_num");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step_chk("restart_if", c_if(1'b1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
